// File: rtl/cfg_loader.sv
// Serial frame loader (sync, addr MSB-first, payload LSB-first, even parity) writing per-cell config slices.
// Commit/flag at the parity-sample edge; no backpressure, bit_valid gaps simply hold all state.
module cfg_loader #(
    parameter int          NUM_CELLS = 3,
    parameter int          CFG_W     = 31,
    parameter int          ADDR_W    = 2,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       clear,
    output logic [NUM_CELLS*CFG_W-1:0] cfg_flat,
    output logic                       frame_ok,
    output logic                       frame_err,
    output logic                       err_sticky,
    output logic                       busy,
    output logic                       all_cfg
);

    localparam int CNT_W = $clog2(CFG_W + 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_ADDR   = 2'd1,
        S_DATA   = 2'd2,
        S_PARITY = 2'd3
    } state_t;

    state_t                     r_state;
    logic [7:0]                 r_shift;
    logic [CNT_W-1:0]           r_cnt;
    logic [ADDR_W-1:0]          r_addr;
    logic [CFG_W-1:0]           r_shadow;
    logic                       r_par;
    logic [NUM_CELLS-1:0]       r_mask;
    logic [NUM_CELLS*CFG_W-1:0] r_cfg_flat;
    logic                       r_frame_ok;
    logic                       r_frame_err;
    logic                       r_err_sticky;
    logic                       r_all_cfg;

    logic [7:0]                 w_shift_nxt;
    logic                       w_par_edge;
    logic                       w_good;
    logic                       w_commit;
    logic                       w_err;
    logic [NUM_CELLS-1:0]       w_mask_nxt;

    assign w_shift_nxt = {r_shift[6:0], bit_in};
    assign w_par_edge  = bit_valid && (r_state == S_PARITY);
    // Running parity covers addr+payload; the incoming bit completes the even check.
    assign w_good      = ((r_par ^ bit_in) == 1'b0) && (32'(r_addr) < NUM_CELLS);
    assign w_commit    = w_par_edge && w_good;
    assign w_err       = w_par_edge && !w_good;
    assign w_mask_nxt  = (clear ? '0 : r_mask)
                       | (w_commit ? (NUM_CELLS'(1) << r_addr) : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HUNT;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_shadow     <= '0;
            r_par        <= 1'b0;
            r_mask       <= '0;
            r_cfg_flat   <= '0;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_all_cfg    <= 1'b0;
        end else begin
            r_frame_ok   <= w_commit;
            r_frame_err  <= w_err;
            r_mask       <= w_mask_nxt;
            r_all_cfg    <= &w_mask_nxt;
            r_err_sticky <= (r_err_sticky && !clear) || w_err;

            if (w_commit) begin
                for (int c = 0; c < NUM_CELLS; c++) begin
                    if (r_addr == ADDR_W'(c))
                        r_cfg_flat[c*CFG_W +: CFG_W] <= r_shadow;
                end
            end

            if (bit_valid) begin
                case (r_state)
                    S_HUNT: begin
                        if (w_shift_nxt == SYNC) begin
                            r_state <= S_ADDR;
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_par   <= 1'b0;
                        end else begin
                            r_shift <= w_shift_nxt;
                        end
                    end
                    S_ADDR: begin
                        r_addr <= (r_addr << 1) | ADDR_W'(bit_in);
                        r_par  <= r_par ^ bit_in;
                        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shadow <= {bit_in, r_shadow[CFG_W-1:1]};
                        r_par    <= r_par ^ bit_in;
                        if (r_cnt == CNT_W'(CFG_W - 1)) begin
                            r_state <= S_PARITY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_HUNT;
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign cfg_flat   = r_cfg_flat;
    assign frame_ok   = r_frame_ok;
    assign frame_err  = r_frame_err;
    assign err_sticky = r_err_sticky;
    assign all_cfg    = r_all_cfg;
    assign busy       = (r_state != S_HUNT);

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: framing, commit, error, clear and mid-frame reset scenarios.
module tb_cfg_loader;

    logic        clk;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        clear;
    logic [92:0] cfg_flat;
    logic        frame_ok;
    logic        frame_err;
    logic        err_sticky;
    logic        busy;
    logic        all_cfg;

    int tests_run = 0;
    int fails     = 0;

    cfg_loader #(.NUM_CELLS(3), .CFG_W(31), .ADDR_W(2), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .cfg_flat   (cfg_flat),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_sticky (err_sticky),
        .busy       (busy),
        .all_cfg    (all_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
        idle(gap);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits8(input logic [7:0] v, input int maxgap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], maxgap);
    endtask

    // Sends sync..last payload bit and the parity bit; clear optionally rides on the parity edge.
    task automatic send_frame(input logic [1:0] a, input logic [30:0] p,
                              input logic flip, input int maxgap, input logic clr_par);
        logic par;
        send_bits8(8'hA5, maxgap);
        for (int i = 1; i >= 0; i--) send_bit(a[i], maxgap);
        for (int i = 0; i < 31; i++) send_bit(p[i], maxgap);
        par = (^a) ^ (^p) ^ flip;
        idle((maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
        clear = clr_par;
        send_bit(par, 0);
        clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(2);
        tests_run++;
        if (cfg_flat !== 93'd0) begin fails++; $display("FAIL reset_cfg: got %h exp 0", cfg_flat); end
        tests_run++;
        if ({frame_ok, frame_err, err_sticky, busy, all_cfg} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b exp 00000", {frame_ok, frame_err, err_sticky, busy, all_cfg});
        end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_first_frame;
        send_bits8(8'h3C, 0);
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL garbage_busy: got %b exp 0", busy); end
        send_frame(2'd1, 31'h5555_5555, 1'b0, 0, 1'b0);
        tests_run++;
        if (frame_ok !== 1'b1) begin fails++; $display("FAIL first_ok: got %b exp 1", frame_ok); end
        tests_run++;
        if (cfg_flat[61:31] !== 31'h5555_5555) begin fails++; $display("FAIL first_slice1: got %h exp 55555555", cfg_flat[61:31]); end
        tests_run++;
        if ({cfg_flat[92:62], cfg_flat[30:0]} !== 62'd0) begin
            fails++; $display("FAIL first_others: got %h exp 0", {cfg_flat[92:62], cfg_flat[30:0]});
        end
        idle(1);
        tests_run++;
        if (frame_ok !== 1'b0) begin fails++; $display("FAIL first_ok_pulse: got %b exp 0", frame_ok); end
    endtask

    task automatic test_all_cells;
        send_frame(2'd0, 31'h1234_5678, 1'b0, 3, 1'b0);
        tests_run++;
        if ({frame_ok, all_cfg} !== 2'b10) begin fails++; $display("FAIL cells_c0: got ok/all %b exp 10", {frame_ok, all_cfg}); end
        idle(1);
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL cells_busy: got %b exp 0", busy); end
        send_frame(2'd1, 31'h0F0F_0F0F, 1'b0, 3, 1'b0);
        tests_run++;
        if ({frame_ok, all_cfg} !== 2'b10) begin fails++; $display("FAIL cells_c1: got ok/all %b exp 10", {frame_ok, all_cfg}); end
        send_frame(2'd2, 31'h7ABC_DEF0, 1'b0, 3, 1'b0);
        tests_run++;
        if ({frame_ok, all_cfg} !== 2'b11) begin fails++; $display("FAIL cells_c2: got ok/all %b exp 11", {frame_ok, all_cfg}); end
        tests_run++;
        if (cfg_flat !== {31'h7ABC_DEF0, 31'h0F0F_0F0F, 31'h1234_5678}) begin
            fails++; $display("FAIL cells_flat: got %h exp %h", cfg_flat, {31'h7ABC_DEF0, 31'h0F0F_0F0F, 31'h1234_5678});
        end
    endtask

    task automatic test_parity_err;
        send_frame(2'd2, 31'h1111_1111, 1'b1, 1, 1'b0);
        tests_run++;
        if ({frame_ok, frame_err, err_sticky} !== 3'b011) begin
            fails++; $display("FAIL par_flags: got ok/err/sticky %b exp 011", {frame_ok, frame_err, err_sticky});
        end
        tests_run++;
        if (cfg_flat !== {31'h7ABC_DEF0, 31'h0F0F_0F0F, 31'h1234_5678}) begin
            fails++; $display("FAIL par_cfg: got %h exp unchanged", cfg_flat);
        end
        idle(1);
        tests_run++;
        if ({frame_err, err_sticky} !== 2'b01) begin fails++; $display("FAIL par_pulse: got err/sticky %b exp 01", {frame_err, err_sticky}); end
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        tests_run++;
        if ({err_sticky, all_cfg} !== 2'b00) begin fails++; $display("FAIL par_clear: got sticky/all %b exp 00", {err_sticky, all_cfg}); end
        send_frame(2'd2, 31'h1111_1111, 1'b1, 0, 1'b1);
        tests_run++;
        if ({frame_err, err_sticky} !== 2'b11) begin fails++; $display("FAIL par_clear_same_edge: got err/sticky %b exp 11", {frame_err, err_sticky}); end
    endtask

    task automatic test_bad_addr;
        send_frame(2'd3, 31'h0ABC_0123, 1'b0, 0, 1'b0);
        tests_run++;
        if ({frame_ok, frame_err, all_cfg} !== 3'b010) begin
            fails++; $display("FAIL badaddr_flags: got ok/err/all %b exp 010", {frame_ok, frame_err, all_cfg});
        end
        tests_run++;
        if (cfg_flat !== {31'h7ABC_DEF0, 31'h0F0F_0F0F, 31'h1234_5678}) begin
            fails++; $display("FAIL badaddr_cfg: got %h exp unchanged", cfg_flat);
        end
    endtask

    task automatic test_reset_mid;
        logic [30:0] p;
        p = 31'h2AAA_AAAA;
        send_bits8(8'hA5, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        for (int i = 0; i < 10; i++) send_bit(p[i], 0);
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b exp 1", busy); end
        reset = 1'b0;
        #2;
        tests_run++;
        if ({cfg_flat, frame_ok, frame_err, err_sticky, busy, all_cfg} !== 98'd0) begin
            fails++; $display("FAIL mid_reset_outs: got cfg %h flags %b exp all 0", cfg_flat, {frame_ok, frame_err, err_sticky, busy, all_cfg});
        end
        idle(1);
        reset = 1'b1;
        idle(1);
        send_frame(2'd0, p, 1'b0, 0, 1'b0);
        tests_run++;
        if ({frame_ok, cfg_flat} !== {1'b1, 62'd0, 31'h2AAA_AAAA}) begin
            fails++; $display("FAIL mid_resend: got ok %b cfg %h exp ok 1 cfg %h", frame_ok, cfg_flat, {62'd0, 31'h2AAA_AAAA});
        end
    endtask

    task automatic test_back_to_back_clear;
        send_frame(2'd1, 31'h0000_0001, 1'b0, 0, 1'b0);
        send_frame(2'd2, 31'h4000_0000, 1'b0, 0, 1'b0);
        tests_run++;
        if ({frame_ok, all_cfg} !== 2'b11) begin fails++; $display("FAIL b2b_all: got ok/all %b exp 11", {frame_ok, all_cfg}); end
        send_frame(2'd0, 31'h7FFF_FFFF, 1'b0, 0, 1'b1);
        tests_run++;
        if ({frame_ok, all_cfg} !== 2'b10) begin fails++; $display("FAIL clr_commit: got ok/all %b exp 10", {frame_ok, all_cfg}); end
        send_frame(2'd1, 31'h0000_0001, 1'b0, 0, 1'b0);
        tests_run++;
        if (all_cfg !== 1'b0) begin fails++; $display("FAIL clr_mask_c1: got %b exp 0", all_cfg); end
        send_frame(2'd2, 31'h4000_0000, 1'b0, 0, 1'b0);
        tests_run++;
        if (all_cfg !== 1'b1) begin fails++; $display("FAIL clr_mask_c2: got %b exp 1", all_cfg); end
        tests_run++;
        if (cfg_flat !== {31'h4000_0000, 31'h0000_0001, 31'h7FFF_FFFF}) begin
            fails++; $display("FAIL b2b_flat: got %h exp %h", cfg_flat, {31'h4000_0000, 31'h0000_0001, 31'h7FFF_FFFF});
        end
    endtask

    initial begin
        reset     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear     = 1'b0;
        #1;
        test_reset;
        test_first_frame;
        test_all_cells;
        test_parity_err;
        test_bad_addr;
        test_reset_mid;
        test_back_to_back_clear;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
